// File: rtl/mo_pkg.sv
// Shared definitions for the motion-object line buffer.
//   PIX_W       - default pixel colour width
//   ADDR_W      - default horizontal address width (bank depth 2^ADDR_W)
//   TRANSPARENT - colour value that marks an empty / transparent pixel
//   state_t     - line buffer FSM states
package mo_pkg;

    localparam int unsigned PIX_W       = 4;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned TRANSPARENT = 0;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/mo_line_bank.sv
// One line buffer bank: 2^ADDR_W x PIX_W, combinational read, synchronous write.
// Contents are not reset; the owner clears them.
//   clk   - system clock
//   we    - write enable
//   addr  - read/write address
//   wdata - write data
//   rdata - combinational read data at addr
module mo_line_bank #(
    parameter int unsigned PIX_W  = mo_pkg::PIX_W,
    parameter int unsigned ADDR_W = mo_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [PIX_W-1:0]  wdata,
    output logic [PIX_W-1:0]  rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mo_line_buffer.sv
// Double-buffered motion-object line buffer. One bank collects opaque pixels for
// the next scanline while the other is read out to the mixer and cleared behind
// the read. After reset both banks are swept to zero before normal operation.
//   clk       - system clock
//   resetn    - asynchronous active-low reset
//   ce5       - pixel clock enable (gates everything except the clear sweep)
//   line_sel  - 0: bank A written / bank B read; 1: roles swapped
//   addr1     - bank A address
//   addr2     - bank B address
//   pix_in    - pixel for the write-side bank
//   mo_pix    - registered read-side pixel
//   mo_opaque - registered, high when mo_pix is non-transparent
//   init_busy - high while the post-reset clear sweep runs
module mo_line_buffer #(
    parameter int unsigned PIX_W      = mo_pkg::PIX_W,
    parameter int unsigned ADDR_W     = mo_pkg::ADDR_W,
    parameter bit          FIRST_WINS = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ce5,
    input  logic              line_sel,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [PIX_W-1:0]  pix_in,
    output logic [PIX_W-1:0]  mo_pix,
    output logic              mo_opaque,
    output logic              init_busy
);

    import mo_pkg::state_t;
    import mo_pkg::INIT;
    import mo_pkg::RUN;
    import mo_pkg::TRANSPARENT;

    localparam logic [PIX_W-1:0] CLEAR = PIX_W'(TRANSPARENT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [PIX_W-1:0]  mo_pix_q;
    logic              mo_opaque_q;

    logic              we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [PIX_W-1:0]  wdata_a, wdata_b;
    logic [PIX_W-1:0]  rdata_a, rdata_b;
    logic [PIX_W-1:0]  wr_rdata, rd_rdata;
    logic              wr_ok;

    // Address muxing kept apart from the write-enable logic so the read data
    // feeding the priority compare has no path back through it.
    assign addr_a = (state_q == INIT) ? clr_addr_q : addr1;
    assign addr_b = (state_q == INIT) ? clr_addr_q : addr2;

    assign wr_rdata = line_sel ? rdata_b : rdata_a;
    assign rd_rdata = line_sel ? rdata_a : rdata_b;

    // Transparent pixels never write; with FIRST_WINS an opaque pixel already
    // on the line keeps priority over later ones.
    assign wr_ok = (pix_in != CLEAR) && (!FIRST_WINS || (wr_rdata == CLEAR));

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        we_a       = 1'b0;
        we_b       = 1'b0;
        wdata_a    = CLEAR;
        wdata_b    = CLEAR;
        unique case (state_q)
            INIT: begin
                we_a       = 1'b1;
                we_b       = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (&clr_addr_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ce5) begin
                    if (line_sel) begin
                        we_a    = 1'b1;  // read-then-clear
                        we_b    = wr_ok;
                        wdata_b = pix_in;
                    end else begin
                        we_b    = 1'b1;  // read-then-clear
                        we_a    = wr_ok;
                        wdata_a = pix_in;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= INIT;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mo_pix_q    <= CLEAR;
            mo_opaque_q <= 1'b0;
        end else if (state_q == INIT) begin
            mo_pix_q    <= CLEAR;
            mo_opaque_q <= 1'b0;
        end else if (ce5) begin
            mo_pix_q    <= rd_rdata;
            mo_opaque_q <= (rd_rdata != CLEAR);
        end
    end

    assign mo_pix    = mo_pix_q;
    assign mo_opaque = mo_opaque_q;
    assign init_busy = (state_q == INIT);

    mo_line_bank #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_bank_a (
        .clk   (clk),
        .we    (we_a),
        .addr  (addr_a),
        .wdata (wdata_a),
        .rdata (rdata_a)
    );

    mo_line_bank #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_bank_b (
        .clk   (clk),
        .we    (we_b),
        .addr  (addr_b),
        .wdata (wdata_b),
        .rdata (rdata_b)
    );

endmodule

// File: tb/tb_mo_line_buffer.sv
// Bench for mo_line_buffer. Two instances share all stimulus: dut1 with
// FIRST_WINS=1 and dut0 with FIRST_WINS=0, so the priority rule is checked both ways.
module tb_mo_line_buffer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ce5;
    logic       line_sel;
    logic [7:0] addr1, addr2;
    logic [3:0] pix_in;
    logic [3:0] mo_pix1, mo_pix0;
    logic       mo_opaque1, mo_opaque0;
    logic       init_busy1, init_busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mo_line_buffer #(
        .PIX_W      (4),
        .ADDR_W     (8),
        .FIRST_WINS (1'b1)
    ) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .ce5       (ce5),
        .line_sel  (line_sel),
        .addr1     (addr1),
        .addr2     (addr2),
        .pix_in    (pix_in),
        .mo_pix    (mo_pix1),
        .mo_opaque (mo_opaque1),
        .init_busy (init_busy1)
    );

    mo_line_buffer #(
        .PIX_W      (4),
        .ADDR_W     (8),
        .FIRST_WINS (1'b0)
    ) dut0 (
        .clk       (clk),
        .resetn    (resetn),
        .ce5       (ce5),
        .line_sel  (line_sel),
        .addr1     (addr1),
        .addr2     (addr2),
        .pix_in    (pix_in),
        .mo_pix    (mo_pix0),
        .mo_opaque (mo_opaque0),
        .init_busy (init_busy0)
    );

    typedef struct {
        logic       ce;
        logic       ls;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [3:0] pix;
        logic [3:0] e1;  // expected mo_pix, FIRST_WINS=1
        logic [3:0] e0;  // expected mo_pix, FIRST_WINS=0
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic ce, input logic ls, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [3:0] p);
        ce5      = ce;
        line_sel = ls;
        addr1    = a1;
        addr2    = a2;
        pix_in   = p;
        @(posedge clk);
        #1;
    endtask

    // Count edges until the clear sweep ends; bounded so a stuck FSM still finishes.
    task automatic wait_init(input string name);
        int n = 0;
        ce5 = 1'b0;
        while (init_busy1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_len"}, n, 256);
        check({name, "_busy0"}, int'(init_busy0), 0);
    endtask

    // Read every location of both banks; reading also clears, which is harmless here.
    task automatic check_banks_zero(input string name);
        for (int bank = 0; bank < 2; bank++) begin
            int bad = 0;
            for (int a = 0; a < 256; a++) begin
                if (bank == 0) step(1'b1, 1'b1, 8'(a), 8'h00, 4'd0);
                else           step(1'b1, 1'b0, 8'h00, 8'(a), 4'd0);
                if (mo_pix1 != 0 || mo_pix0 != 0 || mo_opaque1 || mo_opaque0) bad++;
            end
            check({name, (bank == 0) ? "_bankA_nonzero" : "_bankB_nonzero"}, bad, 0);
        end
    endtask

    initial begin
        int bad;

        // Ping-pong, priority and wrap/concurrency vectors.
        vecs.push_back('{1'b1, 1'b0, 8'h40, 8'h00, 4'd5,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h40, 8'h00, 4'd0,  4'd5,  4'd5});
        vecs.push_back('{1'b1, 1'b1, 8'h40, 8'h00, 4'd0,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h10, 4'd3,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h10, 4'd0,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h80, 8'h10, 4'd9,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b0, 8'h80, 8'h10, 4'd0,  4'd3,  4'd9});
        vecs.push_back('{1'b1, 1'b0, 8'h80, 8'h10, 4'd0,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h81, 8'h60, 4'd8,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h82, 8'h61, 4'd9,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h83, 8'h62, 4'd10, 4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b0, 8'hFE, 8'h60, 4'd1,  4'd8,  4'd8});
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h61, 4'd2,  4'd9,  4'd9});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h62, 4'd4,  4'd10, 4'd10});
        vecs.push_back('{1'b1, 1'b1, 8'hFE, 8'h60, 4'd0,  4'd1,  4'd1});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 8'h61, 4'd0,  4'd2,  4'd2});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h62, 4'd0,  4'd4,  4'd4});
        vecs.push_back('{1'b1, 1'b0, 8'hFE, 8'h60, 4'd0,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h61, 4'd0,  4'd0,  4'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 8'h62, 4'd0,  4'd0,  4'd0});

        resetn   = 1'b0;
        ce5      = 1'b0;
        line_sel = 1'b0;
        addr1    = '0;
        addr2    = '0;
        pix_in   = '0;
        #12;
        check("rst_mo_pix", int'(mo_pix1), 0);
        check("rst_mo_opaque", int'(mo_opaque1), 0);
        check("rst_init_busy", int'(init_busy1), 1);

        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_init("init");
        check_banks_zero("post_init");

        foreach (vecs[i]) begin
            step(vecs[i].ce, vecs[i].ls, vecs[i].a1, vecs[i].a2, vecs[i].pix);
            check($sformatf("vec%0d_pix1", i), int'(mo_pix1), int'(vecs[i].e1));
            check($sformatf("vec%0d_opq1", i), int'(mo_opaque1), int'(vecs[i].e1 != 0));
            check($sformatf("vec%0d_pix0", i), int'(mo_pix0), int'(vecs[i].e0));
        end

        // ce5 gating: output holds, no writes on the write side, no clears on the read side.
        step(1'b1, 1'b0, 8'h22, 8'h30, 4'd7);
        step(1'b1, 1'b0, 8'h23, 8'h31, 4'd11);
        step(1'b1, 1'b1, 8'h22, 8'h30, 4'd0);
        check("gate_pre", int'(mo_pix1), 7);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h23, 8'(8'h50 + i), 4'd7);
            if (mo_pix1 != 7 || !mo_opaque1 || mo_pix0 != 7) bad++;
        end
        check("gate_hold", bad, 0);
        step(1'b1, 1'b1, 8'h23, 8'h30, 4'd0);
        check("gate_no_clear", int'(mo_pix1), 11);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h00, 8'(8'h50 + i), 4'd0);
            if (mo_pix1 != 0 || mo_pix0 != 0) bad++;
        end
        check("gate_no_write", bad, 0);
        check_banks_zero("post_run");

        // Mid-RUN reset: outputs clear asynchronously, sweep wipes leftover data.
        step(1'b1, 1'b0, 8'h33, 8'h70, 4'd6);
        step(1'b1, 1'b1, 8'h33, 8'h70, 4'd6);
        check("pre_reset_pix", int'(mo_pix1), 6);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_pix", int'(mo_pix1), 0);
        check("async_rst_opq", int'(mo_opaque1), 0);
        check("async_rst_busy", int'(init_busy1), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_init("rerun");
        check_banks_zero("post_rerun");

        // Mid-INIT reset: sweep must restart from address 0.
        step(1'b1, 1'b0, 8'h44, 8'h45, 4'd12);
        step(1'b1, 1'b1, 8'h44, 8'h45, 4'd13);
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        #2;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        wait_init("reinit");
        check_banks_zero("post_reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
